// File: rtl/sram_arbiter_if.sv
// Requester-side bus of the SRAM arbiter: two request ports (IFU = 0, LSU = 1)
// and a shared response path qualified per port by rsp_valid.
interface sram_arbiter_if #(
  parameter int DW = 32,
  parameter int MW = 4,
  parameter int AW = 32
);
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [2*AW-1:0] req_addr;
  logic [1:0]      req_we;
  logic [2*MW-1:0] req_wem;
  logic [2*DW-1:0] req_wdata;
  logic [1:0]      rsp_valid;
  logic [1:0]      rsp_ready;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err;

  modport master (
    output req_valid, req_addr, req_we, req_wem, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_we, req_wem, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between IFU and LSU,
// one outstanding response, one request per cycle sustained.
//
// state | meaning
// IDLE  | no response pending
// RSP   | one response pending for owner_q (we_q / err_q / waddr_q registered)
module sram_arbiter #(
  parameter int DP = 512,
  parameter int DW = 32,
  parameter int MW = 4,
  parameter int AW = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  sram_arbiter_if.slave   bus,
  output logic [AW-1:0]   ram_addr,
  output logic [DW-1:0]   ram_din,
  output logic            ram_we,
  output logic [MW-1:0]   ram_wem,
  input  logic [DW-1:0]   ram_dout
);

  typedef enum logic {IDLE, RSP} state_t;

  state_t        state_q;
  logic          owner_q;
  logic          we_q;
  logic          err_q;
  logic          last_q;
  logic [AW-1:0] waddr_q;

  logic          in_rsp;
  logic          rsp_hs;
  logic          accept;
  logic          gnt;
  logic          grant_en;
  logic          sel_we;
  logic          sel_oor;
  logic [AW-1:0] sel_addr;
  logic [AW-1:0] sel_word;
  logic [DW-1:0] sel_wdata;
  logic [MW-1:0] sel_wem;

  // Reset gates every output so nothing leaks while the state is unknown.
  always_comb begin
    in_rsp    = rst_n && (state_q == RSP);
    rsp_hs    = in_rsp && bus.rsp_ready[owner_q];
    accept    = rst_n && ((state_q == IDLE) || rsp_hs);
    gnt       = (&bus.req_valid) ? ~last_q : bus.req_valid[1];
    grant_en  = accept && (|bus.req_valid);
    sel_addr  = gnt ? bus.req_addr[AW +: AW]  : bus.req_addr[0 +: AW];
    sel_wdata = gnt ? bus.req_wdata[DW +: DW] : bus.req_wdata[0 +: DW];
    sel_wem   = gnt ? bus.req_wem[MW +: MW]   : bus.req_wem[0 +: MW];
    sel_we    = bus.req_we[gnt];
    sel_word  = sel_addr >> 2;
    sel_oor   = sel_word >= AW'(DP);
  end

  assign bus.req_ready = grant_en ? (gnt ? 2'b10 : 2'b01) : 2'b00;
  assign bus.rsp_valid = in_rsp ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign bus.rsp_err   = in_rsp && err_q;
  assign bus.rsp_rdata = (in_rsp && !we_q && !err_q) ? ram_dout : '0;

  assign ram_we   = grant_en && sel_we && !sel_oor;
  assign ram_wem  = ram_we ? sel_wem : '0;
  assign ram_din  = sel_wdata;
  // Holding the pending word address keeps ram_dout stable under backpressure.
  assign ram_addr = grant_en ? sel_word : (in_rsp ? waddr_q : '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      last_q  <= 1'b0;
      waddr_q <= '0;
    end else if (grant_en) begin
      state_q <= RSP;
      owner_q <= gnt;
      we_q    <= sel_we;
      err_q   <= sel_oor;
      last_q  <= gnt;
      waddr_q <= sel_word;
    end else if (rsp_hs) begin
      state_q <= IDLE;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural SRAM macro model.
module tb_sram_arbiter;
  localparam int DP = 512;
  localparam int DW = 32;
  localparam int MW = 4;
  localparam int AW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sram_arbiter_if #(.DW(DW), .MW(MW), .AW(AW)) bus();

  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;
  logic          ram_we;
  logic [MW-1:0] ram_wem;

  sram_arbiter #(.DP(DP), .DW(DW), .MW(MW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
    .ram_wem(ram_wem), .ram_dout(ram_dout)
  );

  // SRAM macro: latches address when not writing; out-of-range reads give junk
  logic [DW-1:0] mem [0:DP-1];
  logic [AW-1:0] lat;

  always @(posedge clk) begin
    if (!rst_n) begin
      mem[1]   <= 32'h1234_5678;
      mem[2]   <= 32'h0101_0101;
      mem[511] <= 32'hCAFE_F00D;
    end
    if (ram_we) begin
      for (int b = 0; b < MW; b++)
        if (ram_wem[b]) mem[ram_addr[8:0]][b*8 +: 8] <= ram_din[b*8 +: 8];
    end else begin
      lat <= ram_addr;
    end
  end

  assign ram_dout = (lat < AW'(DP)) ? mem[lat[8:0]] : 32'hDEAD_BEEF;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_cyc(input string tag, input logic [1:0] rdy, input logic [1:0] vld,
                         input logic [31:0] rdata, input logic err, input logic we);
    chk({tag, ".ready"}, 64'(bus.req_ready), 64'(rdy));
    chk({tag, ".rsp_valid"}, 64'(bus.rsp_valid), 64'(vld));
    chk({tag, ".rdata"}, 64'(bus.rsp_rdata), 64'(rdata));
    chk({tag, ".err"}, 64'(bus.rsp_err), 64'(err));
    chk({tag, ".ram_we"}, 64'(ram_we), 64'(we));
  endtask

  task automatic req(input int p, input logic we, input logic [AW-1:0] addr,
                     input logic [MW-1:0] wem, input logic [DW-1:0] wdata);
    bus.req_valid[p] = 1'b1;
    bus.req_we[p] = we;
    bus.req_addr[p*AW +: AW] = addr;
    bus.req_wem[p*MW +: MW] = wem;
    bus.req_wdata[p*DW +: DW] = wdata;
  endtask

  task automatic drop(input int p);
    bus.req_valid[p] = 1'b0;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic next();
    @(negedge clk);
  endtask

  logic [1:0]  tie_rdy   [4] = '{2'b10, 2'b01, 2'b10, 2'b01};
  logic [1:0]  tie_vld   [4] = '{2'b00, 2'b10, 2'b01, 2'b10};
  logic [31:0] tie_rdata [4] = '{32'h0, 32'h0101_0101, 32'h1234_5678, 32'h0101_0101};

  initial begin
    bus.req_valid = '0; bus.req_we = '0; bus.req_addr = '0;
    bus.req_wem = '0; bus.req_wdata = '0; bus.rsp_ready = 2'b11;

    // Reset with both requesters already valid
    req(0, 1'b0, 32'h4, '0, '0);
    req(1, 1'b0, 32'h8, '0, '0);
    next(); settle();
    chk_cyc("rst0", 2'b00, 2'b00, 32'h0, 1'b0, 1'b0);
    chk("rst0.wem", 64'(ram_wem), 64'h0);
    next(); settle();
    chk_cyc("rst1", 2'b00, 2'b00, 32'h0, 1'b0, 1'b0);
    next();

    // Tie from reset: LSU, IFU, LSU, IFU
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk_cyc($sformatf("tie%0d", i), tie_rdy[i], tie_vld[i], tie_rdata[i], 1'b0, 1'b0);
      next();
    end
    bus.req_valid = 2'b00; settle();
    chk_cyc("tie4", 2'b00, 2'b01, 32'h1234_5678, 1'b0, 1'b0); next();
    settle();
    chk_cyc("tie.idle", 2'b00, 2'b00, 32'h0, 1'b0, 1'b0);
    chk("tie.idle.addr", 64'(ram_addr), 64'h0);
    next();

    // Single IFU read
    req(0, 1'b0, 32'h4, '0, '0); settle();
    chk_cyc("rd.c0", 2'b01, 2'b00, 32'h0, 1'b0, 1'b0); next();
    drop(0); settle();
    chk_cyc("rd.c1", 2'b00, 2'b01, 32'h1234_5678, 1'b0, 1'b0); next();
    settle();
    chk_cyc("rd.c2", 2'b00, 2'b00, 32'h0, 1'b0, 1'b0); next();

    // Masked LSU write then read-back
    req(1, 1'b1, 32'h8, 4'b0011, 32'hAABB_CCDD); settle();
    chk_cyc("wr.c0", 2'b10, 2'b00, 32'h0, 1'b0, 1'b1);
    chk("wr.c0.wem", 64'(ram_wem), 64'h3);
    chk("wr.c0.addr", 64'(ram_addr), 64'h2);
    chk("wr.c0.din", 64'(ram_din), 64'hAABB_CCDD);
    next();
    req(1, 1'b0, 32'h8, '0, '0); settle();
    chk_cyc("wr.c1", 2'b10, 2'b10, 32'h0, 1'b0, 1'b0); next();
    drop(1); settle();
    chk_cyc("wr.c2", 2'b00, 2'b10, 32'h0101_CCDD, 1'b0, 1'b0); next();
    settle();
    chk_cyc("wr.idle", 2'b00, 2'b00, 32'h0, 1'b0, 1'b0); next();

    // Backpressure on IFU response while LSU waits with a write
    req(0, 1'b0, 32'h4, '0, '0); settle();
    chk_cyc("bp.c0", 2'b01, 2'b00, 32'h0, 1'b0, 1'b0); next();
    drop(0);
    req(1, 1'b1, 32'h8, 4'hF, 32'h5566_7788);
    bus.rsp_ready = 2'b10;
    for (int i = 1; i <= 3; i++) begin
      settle();
      chk_cyc($sformatf("bp.c%0d", i), 2'b00, 2'b01, 32'h1234_5678, 1'b0, 1'b0);
      chk($sformatf("bp.c%0d.addr", i), 64'(ram_addr), 64'h1);
      next();
    end
    bus.rsp_ready = 2'b11; settle();
    chk_cyc("bp.c4", 2'b10, 2'b01, 32'h1234_5678, 1'b0, 1'b1); next();
    drop(1); settle();
    chk_cyc("bp.c5", 2'b00, 2'b10, 32'h0, 1'b0, 1'b0); next();
    settle();
    chk_cyc("bp.idle", 2'b00, 2'b00, 32'h0, 1'b0, 1'b0); next();

    // Range boundary: word DP is out of range, word DP-1 is not
    req(1, 1'b1, 32'h800, 4'hF, 32'hFFFF_FFFF); settle();
    chk_cyc("oor.c0", 2'b10, 2'b00, 32'h0, 1'b0, 1'b0);
    chk("oor.c0.wem", 64'(ram_wem), 64'h0);
    next();
    drop(1); req(0, 1'b0, 32'h7FC, '0, '0); settle();
    chk_cyc("oor.c1", 2'b01, 2'b10, 32'h0, 1'b1, 1'b0); next();
    drop(0); settle();
    chk_cyc("oor.c2", 2'b00, 2'b01, 32'hCAFE_F00D, 1'b0, 1'b0); next();
    req(0, 1'b0, 32'h800, '0, '0); settle();
    chk_cyc("oor.c3", 2'b01, 2'b00, 32'h0, 1'b0, 1'b0); next();
    drop(0); settle();
    chk_cyc("oor.c4", 2'b00, 2'b01, 32'h0, 1'b1, 1'b0); next();
    settle();
    chk_cyc("oor.idle", 2'b00, 2'b00, 32'h0, 1'b0, 1'b0); next();

    // Reset while a response is pending; last grant was LSU
    req(1, 1'b0, 32'h4, '0, '0); settle();
    chk_cyc("mid.c0", 2'b10, 2'b00, 32'h0, 1'b0, 1'b0); next();
    drop(1); bus.rsp_ready = 2'b00; rst_n = 1'b0; settle();
    chk_cyc("mid.rst", 2'b00, 2'b00, 32'h0, 1'b0, 1'b0); next();
    rst_n = 1'b1; bus.rsp_ready = 2'b11;
    req(0, 1'b0, 32'h4, '0, '0);
    req(1, 1'b0, 32'h8, '0, '0); settle();
    chk_cyc("mid.tie", 2'b10, 2'b00, 32'h0, 1'b0, 1'b0); next();
    bus.req_valid = 2'b00; settle();
    chk_cyc("mid.rsp", 2'b00, 2'b10, 32'h0101_0101, 1'b0, 1'b0); next();
    settle();
    chk_cyc("mid.idle", 2'b00, 2'b00, 32'h0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter DP, default 512: RAM depth in words.
REQ-002 Parameter DW, default 32: data width.
REQ-003 Parameter MW, default 4: byte write-mask width.
REQ-004 Parameter AW, default 32: requester byte-address width and RAM address width.
REQ-005 Port clk, input, 1: single clock; all logic on posedge.
REQ-006 Port rst_n, input, 1: reset, synchronous, active-low.
REQ-007 Port req_valid, input, 2: request valid; bit 0 = IFU, bit 1 = LSU.
REQ-008 Port req_ready, output, 2: request accepted when valid and ready are both 1.
REQ-009 Port req_addr, input, 2*AW: byte address; port p uses slice [p*AW +: AW].
REQ-010 Port req_we, input, 2: 1 = write, 0 = read.
REQ-011 Port req_wem, input, 2*MW: byte write mask.
REQ-012 Port req_wdata, input, 2*DW: write data.
REQ-013 Port rsp_valid, output, 2: response valid, one per port.
REQ-014 Port rsp_ready, input, 2: response consumed when valid and ready are both 1.
REQ-015 Port rsp_rdata, output, DW: read data, shared by both ports and qualified by rsp_valid.
REQ-016 Port rsp_err, output, 1: address out of range for the current response.
REQ-017 Ports ram_addr (AW, out), ram_din (DW, out), ram_we (1, out), ram_wem (MW, out) and ram_dout (DW, in) connect to the SRAM macro.

Function
REQ-018 The SRAM contract is fixed:
- The macro latches ram_addr on every cycle where ram_we=0.
- ram_dout shows the word at the latched address and holds it while the address is unchanged.
- A write with ram_we=1 and ram_wem completes in one cycle.
REQ-019 ram_addr SHALL equal the selected byte address shifted right by 2; ram_din SHALL equal the selected wdata.
REQ-020 The FSM SHALL have two states: IDLE (no response pending) and RSP (one response pending; owner, we and err are registered).
REQ-021 A new request SHALL be accepted only in IDLE, or in RSP in the same cycle the pending response handshakes; at most one grant per cycle.
REQ-022 Arbitration SHALL be round-robin:
- With a single valid requester, that requester is granted.
- With both valid, the port not granted most recently wins.
- The last-granted pointer updates on every accepted request.
REQ-023 req_ready[p] SHALL be combinational: 1 only for the granted port in an accepting cycle, else 0.
REQ-024 On an accepted in-range write, ram_we SHALL be 1 and ram_wem SHALL equal req_wem for that cycle only.
REQ-025 In every other cycle, ram_we and ram_wem SHALL be 0.
REQ-026 The request SHALL be out of range when its word index is DP or greater. An out-of-range request:
- performs no RAM write;
- returns rsp_err=1 and rsp_rdata=0.
REQ-027 After an accepted request, the FSM SHALL be in RSP and rsp_valid[owner] SHALL be 1 on the next cycle: read latency 1, write-ack latency 1.
REQ-028 In RSP, rsp_rdata SHALL be ram_dout for an in-range read, else 0.
REQ-029 In RSP without the response handshake:
- ram_addr is held at the pending word address and ram_we=0, so ram_dout stays stable;
- rsp_valid, rsp_rdata and rsp_err stay stable.
REQ-030 On the response handshake with no new grant, the FSM SHALL return to IDLE.
REQ-031 On the response handshake with a new grant, the FSM SHALL stay in RSP with the new owner. Sustained throughput SHALL be one request per cycle.
REQ-032 In IDLE with no request, ram_addr SHALL be 0, ram_we 0 and rsp_valid 0.
REQ-033 rsp_valid SHALL never be 1 on both bits at once.

Reset
REQ-034 When rst_n=0 at posedge clk, the block SHALL enter IDLE.
REQ-035 The same reset SHALL clear the pending owner, we and err, and set the last-granted pointer to IFU, so the LSU wins the first tie.
REQ-036 During and after reset, until the first grant:
- req_ready, rsp_valid, ram_we and ram_wem are 0;
- rsp_rdata and rsp_err are 0.
REQ-037 Reset asserted in RSP SHALL drop the pending response without issuing any RAM write.

Verification
REQ-038 Single read: RAM word 1 = 0x12345678; IFU reads addr 0x4 with rsp_ready=1. Required: req_ready[0]=1 in cycle 0; rsp_valid[0]=1 and rsp_rdata=0x12345678 in cycle 1; back to IDLE in cycle 2.
REQ-039 Tie and alternation: both ports hold valid reads for 4 cycles from reset with rsp_ready=11. Required: grant order LSU, IFU, LSU, IFU, one grant per cycle.
REQ-040 Masked write: LSU writes 0xAABBCCDD to addr 0x8 with wem=0011 over 0x01010101, then reads addr 0x8. Required: the read returns 0x0101CCDD, and the write ack arrives one cycle after acceptance with rdata 0.
REQ-041 Backpressure: IFU read, then rsp_ready[0]=0 for 3 cycles while the LSU requests. Required: rsp_valid[0] and rsp_rdata hold, ram_we=0, req_ready[1]=0 throughout; the LSU is granted in the cycle rsp_ready[0] rises.
REQ-042 Out of range: LSU writes byte addr 4*DP (0x800). Required: ram_we stays 0, and the next cycle gives rsp_valid[1]=1, rsp_err=1, rsp_rdata=0.
REQ-043 Reset mid-op: rst_n=0 while in RSP. Required: next cycle rsp_valid=00, state IDLE, and the next tie goes to the LSU.
